// File: rtl/ddr_game_timer.sv
// Purpose: game countdown kept as BCD M:SS, with an end-of-game warning window, display blink and a time_up pulse.
// Latency: digits/running/time_up change at the edge that samples the tick or start; warn follows one cycle later; blink one cycle after the enable.
// Backpressure: none. Seconds arriving while idle, paused or done are dropped, and a tick that coincides with start is discarded.
module ddr_game_timer #(
  parameter int GAME_SECONDS = 90,
  parameter int WARN_SECONDS = 10,
  parameter int BLINK_DIV    = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       oneHz_CLK,
  input  logic       display_CLK,
  output logic [3:0] min_bcd,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       time_up,
  output logic       warn,
  output logic       blink
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  localparam logic [3:0] RL_MIN  = 4'(GAME_SECONDS / 60);
  localparam logic [3:0] RL_TENS = 4'((GAME_SECONDS % 60) / 10);
  localparam logic [3:0] RL_ONES = 4'(GAME_SECONDS % 10);
  localparam logic [6:0] WARN_LIM = 7'(WARN_SECONDS);
  localparam int         BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  state_t        state;
  logic          prev_1hz;
  logic          tick;
  logic          last_sec;
  logic          at_zero;
  logic [6:0]    sec_lo;
  logic [3:0]    dec_min;
  logic [3:0]    dec_tens;
  logic [3:0]    dec_ones;
  logic [BW-1:0] blink_cnt;
  logic          blink_qual;

  assign tick       = oneHz_CLK & ~prev_1hz;
  assign last_sec   = (min_bcd == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd1);
  assign at_zero    = (min_bcd == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd0);
  assign sec_lo     = 7'(sec_tens) * 7'd10 + 7'(sec_ones);
  assign blink_qual = warn || (state == DONE);

  // Previous 1 Hz level for rising-edge detection, sampled in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_1hz <= 1'b0;
    else        prev_1hz <= oneHz_CLK;
  end

  // One-second BCD borrow chain; never applied to 0:00 because the FSM leaves RUN first.
  always_comb begin
    dec_min  = min_bcd;
    dec_tens = sec_tens;
    dec_ones = sec_ones;
    if (sec_ones != 4'd0) begin
      dec_ones = sec_ones - 4'd1;
    end else begin
      dec_ones = 4'd9;
      if (sec_tens != 4'd0) begin
        dec_tens = sec_tens - 4'd1;
      end else begin
        dec_tens = 4'd5;
        dec_min  = min_bcd - 4'd1;
      end
    end
  end

  // Game FSM: owns the digits, running and the one-cycle time_up pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      min_bcd  <= RL_MIN;
      sec_tens <= RL_TENS;
      sec_ones <= RL_ONES;
      running  <= 1'b0;
      time_up  <= 1'b0;
    end else begin
      time_up <= 1'b0;
      if (start) begin
        // start wins in every state; a coincident tick is dropped
        state    <= RUN;
        min_bcd  <= RL_MIN;
        sec_tens <= RL_TENS;
        sec_ones <= RL_ONES;
        running  <= 1'b1;
      end else begin
        case (state)
          RUN: begin
            if (pause) begin
              state   <= PAUSED;
              running <= 1'b0;
            end else if (tick) begin
              min_bcd  <= dec_min;
              sec_tens <= dec_tens;
              sec_ones <= dec_ones;
              if (last_sec) begin
                state   <= DONE;
                running <= 1'b0;
                time_up <= 1'b1;
              end
            end
          end
          PAUSED: begin
            if (!pause) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          default: ;  // IDLE and DONE wait for start
        endcase
      end
    end
  end

  // Warning window, computed from the registered digits so it trails them by a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) warn <= 1'b0;
    else        warn <= ((state == RUN) || (state == PAUSED)) && (min_bcd == 4'd0) &&
                        (sec_lo <= WARN_LIM) && !at_zero;
  end

  // Blink divider: counts display enables while warning or done, otherwise digits stay lit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink     <= 1'b1;
    end else if (!blink_qual) begin
      blink_cnt <= '0;
      blink     <= 1'b1;
    end else if (display_CLK) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ddr_game_timer.sv
// Bench for ddr_game_timer at default parameters: directed walk through the game flow, then random stimulus.
// Every cycle the outputs are compared with a seconds-based reference model.
// No flow control on the DUT; the bench drives inputs one cycle at a time.
module tb_ddr_game_timer;

  localparam int GAME = 90;
  localparam int WARN = 10;
  localparam int BDIV = 32;

  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_DONE = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       oneHz_CLK = 1'b0;
  logic       display_CLK = 1'b0;
  logic [3:0] min_bcd, sec_tens, sec_ones;
  logic       running, time_up, warn, blink;

  int checks = 0;
  int errors = 0;
  int disp_pct = 50;
  int tu_seen = 0;

  // reference model state: remaining time as plain seconds
  int m_state, m_rem, m_bcnt;
  bit m_prev, m_running, m_time_up, m_warn, m_blink;

  ddr_game_timer #(.GAME_SECONDS(GAME), .WARN_SECONDS(WARN), .BLINK_DIV(BDIV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause),
    .oneHz_CLK(oneHz_CLK), .display_CLK(display_CLK),
    .min_bcd(min_bcd), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .time_up(time_up), .warn(warn), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_rem = GAME; m_bcnt = 0;
    m_prev = 0; m_running = 0; m_time_up = 0; m_warn = 0; m_blink = 1;
  endtask

  task automatic model_step();
    bit tick;
    int n_state, n_rem, n_bcnt;
    bit n_tu, n_warn, n_blink;
    tick = oneHz_CLK && !m_prev;
    n_state = m_state; n_rem = m_rem; n_tu = 0;
    if (start) begin
      n_state = S_RUN; n_rem = GAME;
    end else if (m_state == S_RUN) begin
      if (pause) n_state = S_PAUSED;
      else if (tick) begin
        n_rem = m_rem - 1;
        if (n_rem == 0) begin n_state = S_DONE; n_tu = 1; end
      end
    end else if (m_state == S_PAUSED && !pause) begin
      n_state = S_RUN;
    end
    // with WARN below a minute, "min==0 and SS<=WARN" is just remaining <= WARN
    n_warn = (m_state == S_RUN || m_state == S_PAUSED) && m_rem > 0 && m_rem <= WARN;
    n_bcnt = m_bcnt; n_blink = m_blink;
    if (m_warn || m_state == S_DONE) begin
      if (display_CLK) begin
        n_bcnt = m_bcnt + 1;
        if (n_bcnt == BDIV) begin n_bcnt = 0; n_blink = !m_blink; end
      end
    end else begin
      n_bcnt = 0; n_blink = 1;
    end
    m_state = n_state; m_rem = n_rem; m_time_up = n_tu; m_running = (n_state == S_RUN);
    m_warn = n_warn; m_bcnt = n_bcnt; m_blink = n_blink; m_prev = oneHz_CLK;
  endtask

  task automatic compare_all();
    chk("min", min_bcd, m_rem / 60);
    chk("tens", sec_tens, (m_rem % 60) / 10);
    chk("ones", sec_ones, m_rem % 10);
    chk("running", running, m_running);
    chk("time_up", time_up, m_time_up);
    chk("warn", warn, m_warn);
    chk("blink", blink, m_blink);
  endtask

  // One clock: model follows the sampled inputs, outputs are checked 1 ns later, display enable re-rolled.
  task automatic cyc();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    compare_all();
    if (time_up === 1'b1) tu_seen++;
    display_CLK = ($urandom_range(0, 99) < disp_pct);
  endtask

  task automatic sec_edges(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      oneHz_CLK = 1'b1;
      repeat (hi) cyc();
      oneHz_CLK = 1'b0;
      repeat (lo) cyc();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) cyc();
    #2 rst_n = 1'b1;
    cyc();
    chk("rst_digits", {min_bcd, sec_tens, sec_ones}, 12'h130);
    chk("rst_running", running, 0);

    // start, then three seconds
    pulse_start();
    chk("start_running", running, 1);
    sec_edges(3, 2, 2);
    chk("dir_127", {min_bcd, sec_tens, sec_ones}, 12'h127);

    // pause across five seconds, then release and take one second
    pause = 1'b1;
    sec_edges(5, 2, 2);
    chk("pause_frozen", {min_bcd, sec_tens, sec_ones}, 12'h127);
    chk("pause_running", running, 0);
    pause = 1'b0;
    cyc();
    sec_edges(1, 2, 2);
    chk("unpause_dec", {min_bcd, sec_tens, sec_ones}, 12'h126);

    // long-held 1 Hz level gives exactly one second
    oneHz_CLK = 1'b1;
    repeat (1000) cyc();
    oneHz_CLK = 1'b0;
    cyc();
    chk("held_high", {min_bcd, sec_tens, sec_ones}, 12'h125);

    // run down through 1:00 and 0:10 borrows into DONE
    for (int i = 0; i < 200 && m_rem > 60; i++) sec_edges(1, 2, 2);
    chk("at_100", {min_bcd, sec_tens, sec_ones}, 12'h100);
    sec_edges(1, 2, 2);
    chk("borrow_059", {min_bcd, sec_tens, sec_ones}, 12'h059);
    for (int i = 0; i < 200 && m_rem > 10; i++) sec_edges(1, 2, 2);
    sec_edges(1, 2, 2);
    chk("borrow_009", {min_bcd, sec_tens, sec_ones}, 12'h009);
    chk("warn_in_window", warn, 1);
    tu_seen = 0;
    for (int i = 0; i < 200 && m_state != S_DONE; i++) sec_edges(1, 3, 3);
    chk("done_reached", m_state, S_DONE);
    chk("time_up_once", tu_seen, 1);
    chk("done_digits", {min_bcd, sec_tens, sec_ones}, 12'h000);
    chk("done_warn", warn, 0);
    chk("done_running", running, 0);
    disp_pct = 60;
    sec_edges(20, 10, 10);
    chk("done_hold", {min_bcd, sec_tens, sec_ones}, 12'h000);
    chk("done_no_more_tu", tu_seen, 1);

    // restart from DONE, then start coincident with a tick
    pulse_start();
    chk("restart_digits", {min_bcd, sec_tens, sec_ones}, 12'h130);
    chk("restart_running", running, 1);
    cyc();
    chk("restart_blink", blink, 1);
    oneHz_CLK = 1'b1;
    pulse_start();
    chk("start_tick", {min_bcd, sec_tens, sec_ones}, 12'h130);
    repeat (4) cyc();
    oneHz_CLK = 1'b0;
    cyc();
    chk("start_tick_held", {min_bcd, sec_tens, sec_ones}, 12'h130);

    // run to 0:05, then async reset between clock edges
    for (int i = 0; i < 200 && m_rem > 5; i++) sec_edges(1, 2, 2);
    repeat (3) cyc();
    chk("at_005", {min_bcd, sec_tens, sec_ones}, 12'h005);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_digits", {min_bcd, sec_tens, sec_ones}, 12'h130);
    chk("arst_warn", warn, 0);
    chk("arst_blink", blink, 1);
    chk("arst_running", running, 0);
    chk("arst_time_up", time_up, 0);
    model_reset();
    oneHz_CLK = 1'b1;
    cyc();
    #2 rst_n = 1'b1;
    repeat (3) cyc();
    chk("idle_ignores", {min_bcd, sec_tens, sec_ones}, 12'h130);
    oneHz_CLK = 1'b0;
    cyc();

    // random phase
    disp_pct = 50;
    pulse_start();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) oneHz_CLK = !oneHz_CLK;
      if ($urandom_range(0, 39) == 0) pause = !pause;
      start = ($urandom_range(0, 399) == 0);
      cyc();
    end
    start = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
